// File: rtl/quad_step_decoder_pkg.sv
// Shared Gray-code constants, direction encoding and transition classifier for quadrature decode.
// Pure declarations; no state, no latency, no flow control.
// Consumed by the input filter and the step decoder.
package quad_pkg;

    localparam logic [1:0] QS_00 = 2'b00;
    localparam logic [1:0] QS_01 = 2'b01;
    localparam logic [1:0] QS_11 = 2'b11;
    localparam logic [1:0] QS_10 = 2'b10;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_FWD  = 2'd1,
        DIR_REV  = 2'd2,
        DIR_ERR  = 2'd3
    } dir_t;

    typedef struct packed {
        logic up;
        logic down;
        logic err;
    } step_t;

    // Forward successor in the CW Gray ring 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] qs_succ(input logic [1:0] s);
        logic [1:0] n;
        n = QS_00;
        case (s)
            QS_00:   n = QS_01;
            QS_01:   n = QS_11;
            QS_11:   n = QS_10;
            QS_10:   n = QS_00;
            default: n = QS_00;
        endcase
        return n;
    endfunction

    function automatic dir_t next_dir(input logic [1:0] old_s, input logic [1:0] new_s);
        dir_t d;
        if (new_s == old_s) begin
            d = DIR_NONE;
        end else if (new_s == qs_succ(old_s)) begin
            d = DIR_FWD;
        end else if (old_s == qs_succ(new_s)) begin
            d = DIR_REV;
        end else begin
            d = DIR_ERR;
        end
        return d;
    endfunction

endpackage

// File: rtl/quad_step_decoder_input_filter.sv
// Purpose: 2-flop synchroniser plus stability filter for the raw 2-bit A/B bus.
// Latency: a new level reaches ab_f FILT_CYCLES+1 edges after it is first sampled.
// Backpressure: none; free-running, always accepts the pin levels.
module quad_input_filter
    import quad_pkg::*;
#(
    parameter int FILT_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] ab_raw,
    output logic [1:0] ab_f
);

    localparam logic [4:0] FILT_LEN = 5'(FILT_CYCLES);

    logic [1:0] ab_m;
    logic [1:0] ab_s;
    logic [1:0] cand;
    logic [3:0] cnt;
    logic [4:0] run_len;

    // Length of the current run of identical samples that differ from ab_f, including this edge.
    always_comb begin
        run_len = 5'd1;
        if (ab_s == cand && cnt != 4'd0) begin
            run_len = {1'b0, cnt} + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ab_m <= QS_00;
            ab_s <= QS_00;
            ab_f <= QS_00;
            cand <= QS_00;
            cnt  <= 4'd0;
        end else begin
            ab_m <= ab_raw;
            ab_s <= ab_m;
            if (ab_s == ab_f) begin
                cnt <= 4'd0;
            end else if (run_len >= FILT_LEN) begin
                ab_f <= ab_s;
                cnt  <= 4'd0;
            end else begin
                cnt  <= run_len[3:0];
                cand <= ab_s;
            end
        end
    end

endmodule

// File: rtl/quad_step_decoder.sv
// Purpose: quadrature A/B decode into single-cycle up/down/err pulses with saturating error count.
// Latency: pulse is high for the cycle after edge FILT_CYCLES+2 counted from first pin sample.
// Backpressure: none; en=0 suppresses pulses while position tracking continues.
module quad_step_decoder
    import quad_pkg::*;
#(
    parameter int FILT_CYCLES = 3,
    parameter bit X4          = 1'b1,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             err_clr,
    output logic             up,
    output logic             down,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic [1:0] ab_f;
    logic [1:0] ab_prev;
    logic [1:0] sub_pos;
    dir_t       dir;
    step_t      step_d;

    quad_input_filter #(
        .FILT_CYCLES(FILT_CYCLES)
    ) u_filt (
        .clk    (clk),
        .rst    (rst),
        .ab_raw ({enc_a, enc_b}),
        .ab_f   (ab_f)
    );

    // ab_prev lags ab_f by one edge, so dir is non-NONE for exactly one cycle per accepted change.
    always_comb begin
        dir    = next_dir(ab_prev, ab_f);
        step_d = '0;
        case (dir)
            DIR_FWD: step_d.up   = X4 ? 1'b1 : (sub_pos == 2'd3);
            DIR_REV: step_d.down = X4 ? 1'b1 : (sub_pos == 2'd0);
            DIR_ERR: step_d.err  = 1'b1;
            default: step_d      = '0;
        endcase
        if (!en) begin
            step_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ab_prev <= QS_00;
            sub_pos <= 2'd0;
            up      <= 1'b0;
            down    <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            ab_prev <= ab_f;
            up      <= step_d.up;
            down    <= step_d.down;
            err     <= step_d.err;
            if (en && !X4) begin
                if (dir == DIR_FWD) begin
                    sub_pos <= sub_pos + 2'd1;
                end else if (dir == DIR_REV) begin
                    sub_pos <= sub_pos - 2'd1;
                end
            end
            // Clear wins over a same-cycle increment.
            if (err_clr) begin
                err_cnt <= '0;
            end else if (step_d.err && err_cnt != ERR_MAX) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Randomised and directed stimulus for two decoder instances (X4=1 and X4=0) sharing inputs.
// A behavioural model queues expected pulses; per-instance monitors pop and compare.
module tb_quad_step_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       enc_a;
    logic       enc_b;
    logic       err_clr;
    logic       up4, dn4, er4;
    logic       up1, dn1, er1;
    logic [7:0] ec4, ec1;

    quad_step_decoder #(.FILT_CYCLES(3), .X4(1'b1), .ERR_W(8)) dut_x4 (
        .clk(clk), .rst(rst), .en(en), .enc_a(enc_a), .enc_b(enc_b), .err_clr(err_clr),
        .up(up4), .down(dn4), .err(er4), .err_cnt(ec4)
    );

    quad_step_decoder #(.FILT_CYCLES(3), .X4(1'b0), .ERR_W(8)) dut_x1 (
        .clk(clk), .rst(rst), .en(en), .enc_a(enc_a), .enc_b(enc_b), .err_clr(err_clr),
        .up(up1), .down(dn1), .err(er1), .err_cnt(ec1)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int cyc;
        int kind;
        int ec;
    } ev_t;

    localparam int F       = 3;
    localparam int K_UP    = 1;
    localparam int K_DOWN  = 2;
    localparam int K_ERR   = 3;
    localparam int POS0    = 1 << 20;

    ev_t q4[$];
    ev_t q1[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;
    int  nup[2];
    int  ndn[2];
    int  ner[2];
    int  last_pulse[2];
    int  m_ec = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Position of a Gray code on the CW ring.
    function automatic int gidx(input int v);
        int r;
        case (v)
            0: r = 0;
            1: r = 1;
            3: r = 2;
            default: r = 3;
        endcase
        return r;
    endfunction

    // Reference model: pipeline = 2-sample delay, run-length filter, ring-distance decode.
    initial begin : model
        int s1, s2, abf, runv, run, pend, p_old, p_new, pos, ab_s, d;
        s1 = 0; s2 = 0; abf = 0; runv = 0; run = 0; pend = 0; p_old = 0; p_new = 0; pos = POS0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                s1 = 0; s2 = 0; abf = 0; runv = 0; run = 0; pend = 0; pos = POS0; m_ec = 0;
            end else begin
                d = (pend != 0 && en) ? (gidx(p_new) - gidx(p_old) + 4) % 4 : 0;
                if (err_clr) m_ec = 0;
                else if (d == 2 && m_ec < 255) m_ec++;
                if (d == 1) begin
                    q4.push_back('{cyc, K_UP, m_ec});
                    pos++;
                    if (pos % 4 == 0) q1.push_back('{cyc, K_UP, m_ec});
                end else if (d == 3) begin
                    q4.push_back('{cyc, K_DOWN, m_ec});
                    if (pos % 4 == 0) q1.push_back('{cyc, K_DOWN, m_ec});
                    pos--;
                end else if (d == 2) begin
                    q4.push_back('{cyc, K_ERR, m_ec});
                    q1.push_back('{cyc, K_ERR, m_ec});
                end
                pend = 0;
                ab_s = s2;
                if (ab_s == abf) begin
                    run = 0;
                end else begin
                    if (run > 0 && ab_s == runv) run++;
                    else begin runv = ab_s; run = 1; end
                    if (run >= F) begin
                        pend = 1; p_old = abf; p_new = ab_s; abf = ab_s; run = 0;
                    end
                end
                s2 = s1;
                s1 = {30'd0, enc_a, enc_b};
            end
        end
    end

    function automatic int qsize(input int w);
        return (w != 0) ? q1.size() : q4.size();
    endfunction

    function automatic ev_t qfront(input int w);
        return (w != 0) ? q1[0] : q4[0];
    endfunction

    function automatic ev_t qpop(input int w);
        return (w != 0) ? q1.pop_front() : q4.pop_front();
    endfunction

    task automatic score(input int w, input string tag, input logic u, input logic d,
                         input logic e, input int ec);
        ev_t x;
        int  kind;
        while (qsize(w) > 0) begin
            x = qfront(w);
            if (x.cyc >= cyc) break;
            x = qpop(w);
            tests++;
            fails++;
            $display("FAIL %s_missed: got no pulse, expected kind %0d at cycle %0d", tag, x.kind, x.cyc);
        end
        if (u || d || e) begin
            check({tag, "_onehot"}, int'(u) + int'(d) + int'(e), 1);
            kind = u ? K_UP : (d ? K_DOWN : K_ERR);
            nup[w] += int'(u);
            ndn[w] += int'(d);
            ner[w] += int'(e);
            last_pulse[w] = cyc;
            x.cyc = -1;
            if (qsize(w) > 0) x = qfront(w);
            if (x.cyc == cyc) begin
                x = qpop(w);
                check({tag, "_kind"}, kind, x.kind);
                check({tag, "_errcnt"}, ec, x.ec);
            end else begin
                tests++;
                fails++;
                $display("FAIL %s_spurious: got kind %0d at cycle %0d, expected no pulse", tag, kind, cyc);
            end
        end
    endtask

    initial begin : monitor
        for (int i = 0; i < 2; i++) begin
            nup[i] = 0; ndn[i] = 0; ner[i] = 0; last_pulse[i] = 0;
        end
        forever begin
            @(negedge clk);
            score(0, "x4", up4, dn4, er4, int'(ec4));
            score(1, "x1", up1, dn1, er1, int'(ec1));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] v, input int hold);
        {enc_a, enc_b} = v;
        cycles(hold);
    endtask

    initial begin : stim
        int b_up4, b_dn4, b_er4, b_up1, b_dn1, b_er1, c0, ec_before;
        rst = 1'b1; en = 1'b1; enc_a = 1'b0; enc_b = 1'b0; err_clr = 1'b0;
        cycles(3);
        rst = 1'b0;
        check("rst_up4", int'(up4), 0);
        check("rst_dn4", int'(dn4), 0);
        check("rst_er4", int'(er4), 0);
        check("rst_ec4", int'(ec4), 0);
        check("rst_up1", int'(up1), 0);
        check("rst_dn1", int'(dn1), 0);
        check("rst_ec1", int'(ec1), 0);
        cycles(5);

        // Forward sweep: four x4 steps, one x1 step at the wrap.
        b_up4 = nup[0]; b_dn4 = ndn[0]; b_er4 = ner[0]; b_up1 = nup[1];
        c0 = cyc;
        drive(2'b01, 10);
        check("fwd_latency", last_pulse[0], c0 + 6);
        drive(2'b11, 10); drive(2'b10, 10); drive(2'b00, 10);
        check("fwd_up4", nup[0] - b_up4, 4);
        check("fwd_dn4", ndn[0] - b_dn4, 0);
        check("fwd_er4", ner[0] - b_er4, 0);
        check("fwd_up1", nup[1] - b_up1, 1);

        // Reverse sweep: x1 down fires on the first (0 -> 3) transition.
        b_dn4 = ndn[0]; b_up1 = nup[1]; b_dn1 = ndn[1];
        c0 = cyc;
        drive(2'b10, 10);
        check("rev_x1_latency", last_pulse[1], c0 + 6);
        drive(2'b11, 10); drive(2'b01, 10); drive(2'b00, 10);
        check("rev_dn4", ndn[0] - b_dn4, 4);
        check("rev_dn1", ndn[1] - b_dn1, 1);
        check("rev_up1", nup[1] - b_up1, 0);

        // Glitch rejection on A, then a 3-cycle level that must be accepted.
        drive(2'b01, 10);
        b_up4 = nup[0]; b_dn4 = ndn[0];
        drive(2'b11, 2); drive(2'b01, 10);
        check("glitch2_up4", nup[0] - b_up4, 0);
        check("glitch2_dn4", ndn[0] - b_dn4, 0);
        drive(2'b11, 3); drive(2'b01, 10);
        check("glitch3_up4", nup[0] - b_up4, 1);
        check("glitch3_dn4", ndn[0] - b_dn4, 1);
        drive(2'b00, 10);

        // Illegal double transitions and counter saturation.
        b_up4 = nup[0]; b_dn4 = ndn[0]; b_er4 = ner[0]; b_er1 = ner[1];
        drive(2'b11, 10);
        check("err_first_cnt", int'(ec4), 1);
        for (int i = 0; i < 300; i++) drive((i % 2 == 0) ? 2'b00 : 2'b11, 5);
        cycles(10);
        check("err_sat_ec4", int'(ec4), 255);
        check("err_sat_ec1", int'(ec1), 255);
        check("err_pulses4", ner[0] - b_er4, 301);
        check("err_pulses1", ner[1] - b_er1, 301);
        check("err_no_up4", nup[0] - b_up4, 0);
        check("err_no_dn4", ndn[0] - b_dn4, 0);
        b_er4 = ner[0];
        enc_a = 1'b0; enc_b = 1'b0;
        cycles(4);
        err_clr = 1'b1;
        cycles(3);
        err_clr = 1'b0;
        cycles(5);
        check("clr_vs_err_pulse", ner[0] - b_er4, 1);
        check("clr_vs_err_cnt", int'(ec4), 0);

        // Disabled tracking: only the post-enable transition produces a pulse.
        b_up4 = nup[0]; b_dn4 = ndn[0]; b_er4 = ner[0];
        ec_before = int'(ec4);
        en = 1'b0;
        drive(2'b01, 10); drive(2'b11, 10); drive(2'b10, 10); drive(2'b00, 10);
        en = 1'b1;
        drive(2'b01, 10);
        check("en_up4", nup[0] - b_up4, 1);
        check("en_dn4", ndn[0] - b_dn4, 0);
        check("en_er4", ner[0] - b_er4, 0);
        check("en_ec4", int'(ec4), ec_before);

        // Reset while ab_f=11 and 10 is mid-filter.
        drive(2'b11, 10);
        b_up4 = nup[0]; b_dn4 = ndn[0]; b_er4 = ner[0]; b_up1 = nup[1];
        enc_a = 1'b1; enc_b = 1'b0;
        cycles(2);
        rst = 1'b1;
        enc_a = 1'b0; enc_b = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("mid_rst_up4", int'(up4), 0);
        check("mid_rst_dn4", int'(dn4), 0);
        check("mid_rst_er4", int'(er4), 0);
        check("mid_rst_ec4", int'(ec4), 0);
        cycles(12);
        check("post_rst_up4", nup[0] - b_up4, 1);
        check("post_rst_dn4", ndn[0] - b_dn4, 0);
        check("post_rst_er4", ner[0] - b_er4, 0);
        check("post_rst_up1", nup[1] - b_up1, 0);

        // Random mix of holds (including sub-filter glitches), enables, clears and resets.
        for (int i = 0; i < 500; i++) begin
            rst     = ($urandom_range(99) == 0);
            en      = ($urandom_range(9) != 0);
            err_clr = ($urandom_range(19) == 0);
            drive(2'($urandom_range(3)), $urandom_range(8, 1));
        end
        rst = 1'b0; en = 1'b1; err_clr = 1'b0;
        cycles(20);
        check("drain_q4", q4.size(), 0);
        check("drain_q1", q1.size(), 0);
        check("final_ec4", int'(ec4), m_ec);
        check("final_ec1", int'(ec1), m_ec);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
